// File: rtl/dmem_responder.sv
// Data-memory responder: one request per handshake, read data or store ack LATENCY cycles after accept.
// req_ready is low while a request is in flight; optional address range check under DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W   = $clog2(DEPTH);
  localparam bit         LAT1    = (LATENCY == 1);
  localparam logic [3:0] CNT_INI = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_accept;
  logic              w_enter_resp;

  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_idx;
  logic              w_flag;
  logic              w_op_write;
  logic              w_op_flag;
  logic [IDX_W-1:0]  w_op_idx;
  logic [DATA_W-1:0] w_op_wdata;

  assign w_idx = req_addr[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  logic r_flag;

  assign w_flag    = (req_addr[31:IDX_W+2] != '0) || (req_addr[1:0] != 2'b00);
  assign w_op_flag = LAT1 ? w_flag : r_flag;
  assign rsp_err   = (r_state == RESP) && r_flag;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_flag <= w_flag;
    end
  end
`else
  logic w_unused;

  assign w_flag    = 1'b0;
  assign w_op_flag = w_flag;
  assign rsp_err   = 1'b0;
  assign w_unused  = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
`endif

  // With LATENCY==1 the RESP edge is the accept edge, so the operation comes straight from the inputs.
  assign w_op_write = LAT1 ? req_write : r_write;
  assign w_op_idx   = LAT1 ? w_idx     : r_idx;
  assign w_op_wdata = LAT1 ? req_wdata : r_wdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        req_ready = 1'b1;
        rsp_valid = (r_state == RESP);
        w_accept  = req_valid;
        if (req_valid) begin
          if (LAT1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INI;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_enter_resp = (w_state_nxt == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_enter_resp && !w_op_write) begin
        r_rdata <= w_op_flag ? '0 : r_mem[w_op_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_idx   <= w_idx;
      r_wdata <= req_wdata;
    end
  end

  // Store commits on the edge entering RESP, so a request accepted in RESP sees it.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_op_write && !w_op_flag) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=3 instance for table, handshake, reset and random traffic; LATENCY=1 instance for streaming.
module tb_dmem_responder;

  logic        clk;
  logic        reset;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  dmem_responder #(.DEPTH(256), .LATENCY(3), .DATA_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1), .DATA_W(32)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_rsp    = 0;
  int n_abort  = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_last;

  always @(posedge clk) if (!reset && a_req_valid && a_req_ready) n_acc++;
  always @(negedge clk) if (a_rsp_valid) n_rsp++;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: word memory indexed by (addr/4) mod DEPTH, last load value held between responses.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] er, output logic ee);
    int unsigned idx;
    logic bad;
    idx = (a / 4) % 256;
    bad = RC && ((a >= 32'd1024) || (a % 4 != 0));
    if (w) begin
      if (!bad) m_mem[idx] = d;
    end else begin
      m_last = bad ? 32'h0 : m_mem[idx];
    end
    er = m_last;
    ee = bad;
  endtask

  // Entered at a negedge; returns at the negedge of the RESP cycle (or after a bound expires).
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] got_rd, output logic got_err, output int lat);
    int n;
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = a; a_req_wdata = d;
    n = 0;
    while (!a_req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!a_req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0; a_req_write = 1'($urandom); a_req_addr = $urandom; a_req_wdata = $urandom;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got_rd  = a_rsp_rdata;
    got_err = a_rsp_err;
  endtask

  task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, input string nm,
                     output logic [31:0] rd, output logic er);
    logic [31:0] mr;
    logic me;
    int lat;
    model(w, a, d, mr, me);
    txn(w, a, d, rd, er, lat);
    check({nm, "_lat"}, lat, 32'd3);
    check({nm, "_rdata"}, rd, mr);
    check({nm, "_err"}, {31'b0, er}, {31'b0, me});
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [31:0] rd, mr, exp_b;
    logic er, me, w;
    logic [31:0] a;
    int lat;

    vt[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,                       1'b0};
    vt[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF,                1'b0};
    vt[2] = '{1'b1, 32'h400, 32'h12345678, 32'hDEADBEEF,                RC};
    vt[3] = '{1'b0, 32'h0,   32'h0,        RC ? 32'h0 : 32'h12345678,   1'b0};
    vt[4] = '{1'b0, 32'h3,   32'h0,        RC ? 32'h0 : 32'h12345678,   RC};
    vt[5] = '{1'b1, 32'h400, 32'hAAAAAAAA, RC ? 32'h0 : 32'h12345678,   RC};
    vt[6] = '{1'b0, 32'h0,   32'h0,        RC ? 32'h0 : 32'hAAAAAAAA,   1'b0};
    vt[7] = '{1'b0, 32'h2,   32'h0,        RC ? 32'h0 : 32'hAAAAAAAA,   RC};
    vt[8] = '{1'b1, 32'h3FC, 32'h5A5A5A5A, RC ? 32'h0 : 32'hAAAAAAAA,   1'b0};
    vt[9] = '{1'b0, 32'h7FC, 32'h0,        RC ? 32'h0 : 32'h5A5A5A5A,   RC};

    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    m_last = 32'h0;

    reset = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {31'b0, a_req_ready}, 32'd1);
    check("rst_valid",  {31'b0, a_rsp_valid}, 32'd0);
    check("rst_rdata",  a_rsp_rdata,          32'h0);
    check("rst_err",    {31'b0, a_rsp_err},   32'd0);
    check("rst1_ready", {31'b0, b_req_ready}, 32'd1);
    check("rst1_valid", {31'b0, b_rsp_valid}, 32'd0);
    reset = 1'b0;

    // Known contents everywhere so reads of untouched words are deterministic.
    for (int i = 0; i < 256; i++) txn(1'b1, 32'(i * 4), 32'h0, rd, er, lat);

    // Directed table, issued back-to-back (each request presented in the previous RESP cycle).
    for (int i = 0; i < 10; i++) begin
      run(vt[i].w, vt[i].a, vt[i].d, $sformatf("vec%0d", i), rd, er);
      check($sformatf("vec%0d_tbl_rdata", i), rd, vt[i].rd);
      check($sformatf("vec%0d_tbl_err", i), {31'b0, er}, {31'b0, vt[i].err});
    end

    // LATENCY=1: alternating store/load to 0x4 with req_valid held high.
    exp_b = 32'h0;
    @(negedge clk);
    b_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_req_write = (k % 2 == 0);
      b_req_addr  = 32'h4;
      b_req_wdata = 32'((k / 2 + 1) * 32'h11111111);
      @(posedge clk);
      @(negedge clk);
      if (k % 2 == 1) exp_b = 32'((k / 2 + 1) * 32'h11111111);
      check($sformatf("l1_ready%0d", k), {31'b0, b_req_ready}, 32'd1);
      check($sformatf("l1_valid%0d", k), {31'b0, b_rsp_valid}, 32'd1);
      check($sformatf("l1_rdata%0d", k), b_rsp_rdata, exp_b);
    end
    b_req_valid = 1'b0;

    // Handshake: request held during WAIT with changing fields; only the RESP-cycle value is taken next.
    @(negedge clk);
    model(1'b0, 32'h10, 32'h0, mr, me);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10;
    @(posedge clk); @(negedge clk);
    check("hs_ready_wait1", {31'b0, a_req_ready}, 32'd0);
    a_req_write = 1'b1; a_req_addr = 32'h404; a_req_wdata = 32'hFFFFFFFF;
    @(posedge clk); @(negedge clk);
    check("hs_ready_wait2", {31'b0, a_req_ready}, 32'd0);
    check("hs_novalid_wait", {31'b0, a_rsp_valid}, 32'd0);
    a_req_addr = 32'h14; a_req_wdata = 32'h0BADF00D;
    @(posedge clk); @(negedge clk);
    check("hs_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
    check("hs_rsp_ready", {31'b0, a_req_ready}, 32'd1);
    check("hs_rdata", a_rsp_rdata, mr);
    check("hs_rdata_const", a_rsp_rdata, 32'hDEADBEEF);
    model(1'b1, 32'h14, 32'h0BADF00D, mr, me);
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hs2_lat", lat, 32'd3);
    check("hs2_rdata", a_rsp_rdata, mr);
    run(1'b0, 32'h404, 32'h0, "hs_probe404", rd, er);
    run(1'b0, 32'h14, 32'h0, "hs_probe14", rd, er);
    check("hs_probe14_const", rd, 32'h0BADF00D);

    // Reset during WAIT of a store: store dropped, no response, rdata cleared.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0;
    reset = 1'b1;
    n_abort++;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    m_last = 32'h0;
    check("mid_rst_ready", {31'b0, a_req_ready}, 32'd1);
    check("mid_rst_valid", {31'b0, a_rsp_valid}, 32'd0);
    check("mid_rst_rdata", a_rsp_rdata, 32'h0);
    repeat (5) @(negedge clk);
    run(1'b0, 32'h20, 32'h0, "mid_rst_load", rd, er);
    check("mid_rst_load_const", rd, 32'h0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom);
      if ($urandom % 8 == 0) a = $urandom;
      else a = 32'($urandom_range(0, 15) * 4 + (($urandom % 4 == 0) ? $urandom % 4 : 0));
      if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run(w, a, $urandom, $sformatf("rnd%0d", i), rd, er);
    end

    repeat (4) @(negedge clk);
    check("rsp_count", n_rsp, n_acc - n_abort);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the pipeline's MEM-stage load/store accesses.
- Accepts one request per valid/ready handshake. Returns read data, or a write acknowledge, a fixed LATENCY cycles later.
- Replaces the single-cycle data memory when modelling slow memory. The MEM stage stalls on req_ready/rsp_valid.
- Word-organised storage, byte-addressed interface.

Parameters:
- DEPTH, 256, number of 32-bit words stored. Power of two, >= 2.
- LATENCY, 3, cycles from the accept edge to the rsp_valid cycle. Legal range 1..15.
- DATA_W, 32, data width.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  DATA_W  store data
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  DATA_W  load data; held between responses
- rsp_err  output  1  error flag, qualified by rsp_valid. Tied 0 unless DMEM_RANGE_CHECK_EN is defined.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset is synchronous and active-high: sampled only on the rising edge of clk.
- Reset values (after the reset edge):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - The memory array is NOT cleared by reset. In simulation it is initialised to zero.
- States:
  - IDLE: req_ready = 1.
  - WAIT: req_ready = 0. A down-counter (4 bits) runs.
  - RESP: rsp_valid = 1 for exactly this one cycle, and req_ready = 1.
- Accept:
  - A request is accepted when req_valid && req_ready at a clk edge while reset = 0.
  - req_write, word index and req_wdata are captured into registers at that edge.
  - Inputs may change afterwards.
  - req_valid while req_ready = 0 is ignored. The initiator holds the request until it is accepted.
- Transitions:
  - IDLE/RESP with accept: go to RESP if LATENCY == 1; otherwise go to WAIT with cnt = LATENCY-2.
  - IDLE/RESP without accept: go to IDLE.
  - WAIT with cnt == 0: go to RESP. WAIT with cnt != 0: cnt decrements.
- Latency: a request accepted at edge T gives rsp_valid high in the cycle beginning LATENCY edges later. Throughput is one request per LATENCY cycles.
- Read timing: on the edge entering RESP, rsp_rdata <= mem[idx] for a load.
- Write timing:
  - For a store, rsp_rdata holds its previous value.
  - The write to mem[idx] commits on the same edge that enters RESP.
- Hold: rsp_rdata keeps its value until the next load response or reset.
- Address mapping:
  - idx = req_addr[log2(DEPTH)+1:2].
  - req_addr[1:0] are ignored.
  - Upper bits are ignored, so addresses wrap modulo 4*DEPTH.
- Back-to-back: a request accepted in the RESP cycle sees all earlier stores. A store immediately followed by a load to the same address returns the new data.
- Reset mid-operation:
  - Reset in WAIT or RESP abandons the transaction.
  - A pending store that has not yet reached RESP is discarded.
  - No rsp_valid is produced for it.
- Simultaneous events: reset has priority over accept. A request presented in the reset cycle is not accepted.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- When defined, a request is flagged at accept if req_addr >= 4*DEPTH or req_addr[1:0] != 0. A flagged request:
  - still takes LATENCY cycles;
  - suppresses the memory write;
  - forces rsp_rdata <= 0 for a load;
  - drives rsp_err = 1 in its RESP cycle.
- rsp_err = 0 in all other cycles.
- When not defined: addresses wrap and low bits are ignored as above, and rsp_err is constant 0.

Test Plan:
1. LATENCY=3:
   - Store 0xDEADBEEF to addr 0x10 accepted at edge T → rsp_valid only in cycle T+3, rsp_err = 0.
   - Then load 0x10 accepted in that RESP cycle → rsp_valid 3 cycles later with rsp_rdata = 0xDEADBEEF.
2. LATENCY=1:
   - Alternate store addr 0x4 = 0x11111111 and load 0x4, with req_valid held high.
   - → req_ready stays 1 and rsp_valid is high every cycle.
   - → each load returns the most recent store value.
3. Handshake:
   - Hold req_valid high during WAIT with a changing addr → only the first request is accepted.
   - → a second request is accepted in the RESP cycle.
   - → exactly one rsp_valid per accept.
4. Reset mid-op:
   - Assert reset for 1 cycle in WAIT of a store of 0xCAFEF00D to 0x20.
   - → no rsp_valid; a subsequent load of 0x20 returns the prior contents (0).
   - → rsp_rdata = 0 and req_ready = 1 after the reset edge.
5. Wrap (macro off, DEPTH=256):
   - Store 0x12345678 to 0x400, then load 0x0 → rsp_rdata = 0x12345678.
   - Load 0x3 → rsp_rdata = mem[0], rsp_err = 0.
6. DMEM_RANGE_CHECK_EN, DEPTH=256:
   - Store 0xAAAAAAAA to 0x400 → rsp_err = 1.
   - Then load 0x0 → rsp_rdata unchanged by that store (0), rsp_err = 0.
   - Load 0x2 → rsp_err = 1, rsp_rdata = 0.
